next_block_queue: RTL
=====================

// Module: next_block_queue
// PURPOSE
// Consumer side of the next-block generator. Drives the generator's enable, captures its
// block_info_t output after the generator pipeline latency, and buffers DEPTH pieces.
// Presents the head piece to the game FSM with a valid/take handshake, plus a one-piece
// preview for the "next" display. Sits between gen_next_block and the game-logic FSM.
// PARAMETERS
// DEPTH     2  buffered pieces (>=2); entry 0 = head, entry 1 = preview
// GEN_LAT   3  cycles from gen_en_o high until gen_block_i is valid to sample
// NO_REPEAT 1  1: discard a capture whose color equals the last accepted color (max 1 retry)
// PORTS
// clk_i            in   1                  system clock
// rst_ni           in   1                  async reset, active low
// gen_en_o         out  1                  one-cycle advance pulse to generator en_i
// gen_block_i      in   $bits(block_info_t) generator next_block_o
// take_i           in   1                  game FSM consumes head piece (valid only with block_valid_o)
// block_o          out  $bits(block_info_t) head piece
// block_valid_o    out  1                  block_o holds a piece
// preview_o        out  $bits(block_info_t) piece after head (display only)
// preview_valid_o  out  1                  preview_o holds a piece
// count_o          out  $clog2(DEPTH+1)    pieces stored
// BEHAVIOUR
// - Reset (async assert, sync release): FIFO empty, count_o=0, gen_en_o=0, block_valid_o=0,
//   preview_valid_o=0, block_o=preview_o='0, last_color=0, retry flag clear, FSM=IDLE.
// - FSM IDLE -> REQ when count_o + (request in flight) < DEPTH; at most one request in flight.
// - REQ: gen_en_o=1 for exactly one cycle c; -> WAIT.
// - WAIT: count GEN_LAT cycles; gen_block_i sampled at clock edge ending cycle c+GEN_LAT;
//   -> CAPTURE decision on that edge, then IDLE (or REQ on retry) in cycle c+GEN_LAT+1.
// - Capture accepted: written to FIFO tail; count_o, valid flags update cycle c+GEN_LAT+1.
// - NO_REPEAT=1: if captured color == last accepted color and retry flag clear -> discard,
//   set retry, go REQ immediately; second capture accepted regardless; accept clears retry.
// - Fields x, y, rotation, data, color passed through unmodified.
// - take_i with block_valid_o=1: pop head at edge; preview shifts to head same edge.
//   take_i with block_valid_o=0: ignored, no state change.
// - Simultaneous take and accepted capture: pop and push same edge; count_o unchanged;
//   if count_o was 1, captured piece becomes head (write-to-empty-after-pop ordering).
// - Overflow impossible: slot reserved when request issued. Underflow impossible (take gated).
// - block_valid_o = (count_o>=1); preview_valid_o = (count_o>=2). Outputs registered.
// - Reset asserted mid-WAIT: in-flight request abandoned; generator's later output ignored.
// - Fill latency from reset release: first gen_en_o in cycle 1; head valid in cycle
//   GEN_LAT+2 (no discard); full steady state refilled one request at a time.
// TESTING
// - Reset release, take_i=0: gen_en_o pulses in cycles 1 and 5; block_valid_o rises
//   cycle 5, preview_valid_o cycle 9; no further gen_en_o; count_o=2.
// - Full queue, take_i pulse: block_o <= old preview same edge, count_o 2->1, gen_en_o
//   one cycle later, count_o back to 2 GEN_LAT+1 cycles after that.
// - NO_REPEAT=1, model returns color 3 twice then 5: second capture discarded, extra
//   gen_en_o issued, preview color=5; with consecutive 3,3,3 the second retry-3 is accepted.
// - take_i held high every cycle: exactly one pop per accepted capture, count_o never
//   exceeds 1, no take while block_valid_o=0 changes state.
// - rst_ni low in WAIT (cycle c+2): all outputs zero asynchronously; stale gen_block_i
//   never appears on block_o; refill restarts from cycle 1 after release.
// - Take and capture same edge with count_o=1: count_o stays 1, block_o = captured piece.

Source files
------------

// File: rtl/next_block_queue.sv
// Consumer side of the next-block generator: requests pieces one at a time, captures them
// after the generator latency, buffers DEPTH of them and exposes head plus preview.
module next_block_queue #(
  parameter  int DEPTH     = 2,
  parameter  int GEN_LAT   = 3,
  parameter  int NO_REPEAT = 1,
  parameter  int X_W       = 4,
  parameter  int Y_W       = 5,
  parameter  int ROT_W     = 2,
  parameter  int DATA_W    = 16,
  parameter  int COLOR_W   = 3,
  localparam int BLOCK_W   = X_W + Y_W + ROT_W + DATA_W + COLOR_W,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               gen_en_o,
  input  logic [BLOCK_W-1:0] gen_block_i,
  input  logic               take_i,
  output logic [BLOCK_W-1:0] block_o,
  output logic               block_valid_o,
  output logic [BLOCK_W-1:0] preview_o,
  output logic               preview_valid_o,
  output logic [CNT_W-1:0]   count_o
);

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [ROT_W-1:0]   rotation;
    logic [DATA_W-1:0]  data;
    logic [COLOR_W-1:0] color;
  } block_info_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                          state_q, state_d;
  logic [GEN_LAT:0]                vld_pipe;
  logic [DEPTH-1:0][BLOCK_W-1:0]   fifo_q, fifo_d;
  logic [CNT_W-1:0]                count_q, count_d, wr_idx;
  logic [COLOR_W-1:0]              last_color;
  logic                            retry, bv_q, pv_q;
  block_info_t                     cap;
  logic                            capture, discard, accept, pop;

  // vld_pipe[0] is the request pulse; it reaches the top exactly on the sample cycle.
  assign vld_pipe[0] = (state_q == REQ);
  assign gen_en_o    = vld_pipe[0];

  assign cap     = block_info_t'(gen_block_i);
  assign capture = vld_pipe[GEN_LAT];
  assign discard = (NO_REPEAT != 0) && capture && (cap.color == last_color) && !retry;
  assign accept  = capture && !discard;
  assign pop     = take_i && (count_q != '0);
  assign count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
  assign wr_idx  = count_q - CNT_W'(pop);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (count_q < CNT_W'(DEPTH)) state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: if (capture) begin
        if (discard || count_d < CNT_W'(DEPTH)) state_d = REQ;
        else                                     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop shifts toward the head first, so a push into the freed slot lands behind survivors.
  always_comb begin
    fifo_d = fifo_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) fifo_d[i] = fifo_q[i+1];
      fifo_d[DEPTH-1] = '0;
    end
    for (int i = 0; i < DEPTH; i++)
      if (accept && wr_idx == CNT_W'(i)) fifo_d[i] = gen_block_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      vld_pipe[GEN_LAT:1] <= '0;
      fifo_q           <= '0;
      count_q          <= '0;
      last_color       <= '0;
      retry            <= 1'b0;
      bv_q             <= 1'b0;
      pv_q             <= 1'b0;
    end else begin
      state_q          <= state_d;
      vld_pipe[GEN_LAT:1] <= vld_pipe[GEN_LAT-1:0];
      fifo_q           <= fifo_d;
      count_q          <= count_d;
      bv_q             <= (count_d != '0);
      pv_q             <= (count_d >= CNT_W'(2));
      if (accept) begin
        last_color <= cap.color;
        retry      <= 1'b0;
      end else if (discard) begin
        retry      <= 1'b1;
      end
    end
  end

  assign block_o         = fifo_q[0];
  assign preview_o       = fifo_q[1];
  assign block_valid_o   = bv_q;
  assign preview_valid_o = pv_q;
  assign count_o         = count_q;

endmodule
